// File: rtl/pm_loader.sv
// Program-memory loader: takes a byte stream (16-bit word count, big-endian
// 32-bit words, 8-bit checksum) and writes the words into program memory.
module pm_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pm_wr_en,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [7:0]  csum_fin;
  logic        xfer;

  assign xfer     = in_valid && in_ready;
  assign csum_fin = csum + in_data;

  // Address is derived from the word index so it holds steady through WRITE
  // and sits at BASE_ADDR whenever index is cleared.
  assign pm_wr_addr = BASE_ADDR + ADDR_W'(index);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    pm_wr_en  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_HDR_HI;
      end
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = ({count[15:8], in_data} != 16'd0) ? S_DATA : S_CHK;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        pm_wr_en  = 1'b1;
        state_nxt = (index == count - 16'd1) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      index      <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      pm_wr_data <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            csum     <= '0;
            index    <= '0;
            byte_cnt <= '0;
          end
        end
        S_HDR_HI: if (xfer) count[15:8] <= in_data;
        S_HDR_LO: if (xfer) count[7:0]  <= in_data;
        S_DATA: begin
          // byte_cnt wraps to 0 on the 4th byte, ready for the next word
          if (xfer) begin
            pm_wr_data <= {pm_wr_data[DATA_W-9:0], in_data};
            csum       <= csum_fin;
            byte_cnt   <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: index <= index + 16'd1;
        S_CHK:   if (xfer) err <= (csum_fin != 8'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pm_loader.md
Name: pm_loader

Overview:
- Program-memory loader: the write side of the instruction store that the fetch block reads.
- Accepts a byte stream with a header word count, data words and a checksum, and assembles big-endian 32-bit instructions.
- Writes each instruction into program memory at consecutive addresses.
- Holds the core frozen via busy (feeds stall/stall_pm) while loading, then signals done or error.

Parameters:
- ADDR_W, 16, program-memory address width; matches the fetch block's current_address.
- DATA_W, 32, instruction width; fixed at 4 bytes.
- BASE_ADDR, 16'h0000, address of the first word written.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- pm_wr_en  output  1  program-memory write strobe.
- pm_wr_addr  output  ADDR_W  write address.
- pm_wr_data  output  DATA_W  write data (assembled instruction).
- busy  output  1  load in progress; core must stall.
- done  output  1  one-cycle pulse at end of load.
- err  output  1  checksum mismatch; sticky until next accepted start or reset.

Behaviour:
- Reset (synchronous, active-high, any state):
  - State goes to IDLE.
  - in_ready, pm_wr_en, busy, done and err all go to 0; pm_wr_addr = BASE_ADDR; pm_wr_data = 0.
  - Internal count, index, byte counter and checksum go to 0.
  - Reset mid-load abandons the load; no further writes occur.
- State machine:
  - IDLE -> HDR_HI on start. Clears err, checksum and index.
  - HDR_HI: on a transfer, count[15:8] = byte.
  - HDR_LO: on a transfer, count[7:0] = byte. Go to DATA if the full count is nonzero, else CHK.
  - DATA: accepts 4 bytes, MSB first, shifting into pm_wr_data. Each byte is added to the 8-bit checksum (mod 256). The 4th byte moves to WRITE.
  - WRITE: 1 cycle, no byte accepted.
    - pm_wr_en = 1; pm_wr_addr = BASE_ADDR + index, truncated to ADDR_W (wraps).
    - index increments. Go to CHK if index == count-1, else DATA.
  - CHK: accepts 1 byte. Go to DONE. err = 1 if (checksum + byte) mod 256 != 0.
  - DONE: 1 cycle, done = 1. Returns to IDLE.
- in_ready is 1 exactly in HDR_HI, HDR_LO, DATA and CHK. It is combinational from state and does not depend on in_valid.
- busy is 1 in every state except IDLE. It rises the cycle after start is sampled and falls the cycle after DONE.
- pm_wr_en is 1 only in WRITE. pm_wr_addr and pm_wr_data stay stable while pm_wr_en = 1.
- start while not in IDLE is ignored. start together with reset: reset wins.
- in_valid low stalls the FSM in its state indefinitely. There is no timeout.
- count = 0 performs no writes; the stream is header then checksum (expected checksum byte 0x00).
- Byte-to-write latency: the 4th data byte's transfer cycle is followed by pm_wr_en on the next cycle.
- Minimum load time for N words: 3 + 5N + 2 cycles from start with in_valid held high.

Test Plan:
- Reset then idle: hold reset 2 cycles -> all outputs 0, pm_wr_addr = BASE_ADDR. in_valid high with no start -> in_ready stays 0 and no writes.
- Two-word load, BASE_ADDR = 16'h0008, stream 00 02 12 34 56 78 CA FE BA BE AC ->
  - pm_wr_en pulses twice: addr 0x0008 data 0x12345678, then addr 0x0009 data 0xCAFEBABE.
  - done pulses once; err = 0; busy falls after done.
- Same load with checksum byte 0xAD -> both writes still occur, done pulses, err = 1 and stays 1 until the next start.
- Zero-count load, stream 00 00 00 -> no pm_wr_en; done pulses; err = 0. Stream 00 00 05 -> err = 1.
- Gapped in_valid (one idle cycle between every byte) on the two-word load -> identical writes and data, no bytes dropped. A start pulse asserted mid-load is ignored.
- Reset after the 6th data byte of the two-word load -> one write (0x0008) occurred, none afterwards. busy = 0 and the next start begins a clean load.
